axi_slave_mem: RTL
==================

// Module: axi_slave_mem
// PURPOSE
//   Synthesizable AXI4 burst slave with internal word RAM; the downstream endpoint driven by the
//   axi_master BFM tasks (burst_write / burst_read) in block and system benches.
//   Independent write (AW/W/B) and read (AR/R) engines sharing one memory array.
//   Provides real handshakes, burst sequencing and error responses for master-side verification.
// PARAMETERS
//   ASIZE     32  address width
//   DSIZE     64  data width (bytes per beat = DSIZE/8, power of 2)
//   LSIZE     8   burst length field width (axi_awlen/axi_arlen)
//   IDSIZE    4   transaction ID width
//   MEM_AW    10  log2 of memory depth in DSIZE words
// PORTS
//   axi_aclk     in   1        clock, all logic rising-edge
//   axi_reset    in   1        asynchronous active-high reset
//   axi_awid     in   IDSIZE   write ID      | axi_awaddr  in ASIZE | axi_awlen in LSIZE
//   axi_awburst  in   2        00 FIXED, 01 INCR, 10/11 unsupported
//   axi_awvalid  in   1        / axi_awready out 1
//   axi_wdata    in   DSIZE    / axi_wstrb in DSIZE/8 / axi_wlast in 1
//   axi_wvalid   in   1        / axi_wready  out 1
//   axi_bid      out  IDSIZE   / axi_bresp out 2 / axi_bvalid out 1 / axi_bready in 1
//   axi_arid     in   IDSIZE   / axi_araddr in ASIZE / axi_arlen in LSIZE / axi_arburst in 2
//   axi_arvalid  in   1        / axi_arready out 1
//   axi_rid      out  IDSIZE   / axi_rdata out DSIZE / axi_rresp out 2 / axi_rlast out 1
//   axi_rvalid   out  1        / axi_rready  in 1
//   awsize/arsize/lock/cache/prot/qos not ported: every beat is full DSIZE width.
// BEHAVIOUR
//   Reset: all outputs 0, both FSMs to idle, beat counters 0. RAM contents NOT reset.
//   Word index = addr[MEM_AW+log2(DSIZE/8)-1 : log2(DSIZE/8)]; low byte bits ignored.
//   INCR: index+1 per beat, wraps modulo 2**MEM_AW. FIXED: index constant. No 4KB check.
//   Write FSM:
//     W_IDLE: awready=1. On awvalid&awready latch id/index/len/burst, err=(awburst[1]) -> W_DATA.
//     W_DATA: wready=1. Each wvalid&wready: if !err write bytes where wstrb[i]=1; count++.
//       err set if wlast != (count==len). Beat count (len+1) ends burst, not wlast -> W_RESP.
//     W_RESP: bvalid=1, bid=latched id, bresp=err?2'b10:2'b00; bvalid&bready -> W_IDLE.
//     AW-to-first-wready: 1 cycle. Last W beat to bvalid: 1 cycle. W before AW is not accepted.
//   Read FSM:
//     R_IDLE: arready=1. On handshake latch id/index/len/burst, err=arburst[1] -> R_DATA.
//     R_DATA: rvalid=1, rdata registered from RAM at current index (0 if err), rresp=err?10:00,
//       rlast=(count==len). rvalid&!rready: rdata/rlast/rresp held stable.
//       rvalid&rready: count++, advance index, load next word; after rlast beat -> R_IDLE.
//     AR handshake to first rvalid: 1 cycle. Back-to-back beats at full rate.
//   Same-cycle write and read-register load of one word: read gets pre-write data.
//   Read and write engines run concurrently; one outstanding burst per direction.
//   Reset mid-burst: burst dropped silently, no B/R response issued; partial writes remain.
// CONFIGURATION
//   AXI_SLAVE_BACKPRESSURE_EN defined: 16-bit LFSR (seed 16'hACE1, advances every cycle)
//     gates wready in W_DATA and rvalid in R_DATA, each deasserted when its LFSR tap is 0;
//     rvalid once high stays high until accepted (AXI rule). Also adds 0-3 cycle AW->W delay.
//   Undefined: wready/rvalid as above with no stalls; timing exactly per BEHAVIOUR.
// TESTING
//   1 INCR write len4 @0x100 data 11,22,33,44, awid=3 -> bvalid 1 cyc after beat4, bid=3, bresp=00.
//     Read len4 @0x100 -> rdata 11,22,33,44, rlast only on beat4, rid=arid, rresp=00.
//   2 Word @0x20 = all F; write wstrb=8'h0F data 0 -> read back 64'hFFFFFFFF_00000000.
//   3 FIXED write len3 @0x8 data A,B,C -> FIXED read len2 @0x8 returns C,C.
//   4 INCR len4 with wlast on beat2 -> 4 beats still accepted, bresp=2'b10.
//   5 Read len8, rready low 3 cycles at beat3 -> rdata/rlast stable while stalled, 8 beats in order.
//   6 axi_reset pulse during W_DATA beat2 -> outputs 0 next cycle, no bvalid; fresh
//     len2 burst afterwards completes with bresp=00; rerun 1,5 with AXI_SLAVE_BACKPRESSURE_EN.

Source files
------------

// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//   AXI4 burst slave backed by an internal word-addressed RAM. Independent
//   write (AW/W/B) and read (AR/R) engines share one memory array, with one
//   outstanding burst per direction. FIXED and INCR bursts are supported;
//   burst types 10/11 are accepted but answered with SLVERR (2'b10) and
//   perform no memory access (reads return zero data).
//
// Parameters
//   ASIZE  address width          DSIZE  data width (power-of-2 bytes)
//   LSIZE  burst length width     IDSIZE transaction ID width
//   MEM_AW log2 of memory depth in DSIZE words
//
// Ports
//   axi_aclk / axi_reset                  clock, asynchronous active-high reset
//   axi_aw* / axi_w* / axi_b*             write address, data, response channels
//   axi_ar* / axi_r*                      read address, data channels
//
// Optional feature
//   AXI_SLAVE_BACKPRESSURE_EN: a free-running 16-bit LFSR (seed 16'hACE1)
//   randomly stalls wready and rvalid and inserts a 0-3 cycle AW->W delay.
//   When undefined the slave never stalls.
// ---------------------------------------------------------------------------
module axi_slave_mem #(
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 64,
    parameter int LSIZE  = 8,
    parameter int IDSIZE = 4,
    parameter int MEM_AW = 10
) (
    input  logic                 axi_aclk,
    input  logic                 axi_reset,
    input  logic [IDSIZE-1:0]    axi_awid,
    input  logic [ASIZE-1:0]     axi_awaddr,
    input  logic [LSIZE-1:0]     axi_awlen,
    input  logic [1:0]           axi_awburst,
    input  logic                 axi_awvalid,
    output logic                 axi_awready,
    input  logic [DSIZE-1:0]     axi_wdata,
    input  logic [DSIZE/8-1:0]   axi_wstrb,
    input  logic                 axi_wlast,
    input  logic                 axi_wvalid,
    output logic                 axi_wready,
    output logic [IDSIZE-1:0]    axi_bid,
    output logic [1:0]           axi_bresp,
    output logic                 axi_bvalid,
    input  logic                 axi_bready,
    input  logic [IDSIZE-1:0]    axi_arid,
    input  logic [ASIZE-1:0]     axi_araddr,
    input  logic [LSIZE-1:0]     axi_arlen,
    input  logic [1:0]           axi_arburst,
    input  logic                 axi_arvalid,
    output logic                 axi_arready,
    output logic [IDSIZE-1:0]    axi_rid,
    output logic [DSIZE-1:0]     axi_rdata,
    output logic [1:0]           axi_rresp,
    output logic                 axi_rlast,
    output logic                 axi_rvalid,
    input  logic                 axi_rready
);
    localparam int BW  = DSIZE / 8;
    localparam int OFF = $clog2(BW);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DSIZE-1:0] mem_q [2**MEM_AW];

    // write engine state
    w_state_t            w_state_q;
    logic [IDSIZE-1:0]   wid_q;
    logic [MEM_AW-1:0]   widx_q, widx_d;
    logic [LSIZE-1:0]    wlen_q, wcnt_q;
    logic                wfixed_q, werr_q, werr_d, w_final, w_hs;
    logic                awready_q, wready_q, bvalid_q;
    logic [1:0]          bresp_q;

    // read engine state
    r_state_t            r_state_q;
    logic [IDSIZE-1:0]   rid_q;
    logic [MEM_AW-1:0]   ridx_q, ridx_d, ar_idx;
    logic [LSIZE-1:0]    rlen_q, rcnt_q;
    logic                rfixed_q, rerr_q, r_hs;
    logic                arready_q, rvalid_q, rlast_q;
    logic [1:0]          rresp_q;
    logic [DSIZE-1:0]    rdata_q;

    logic w_allow, r_allow;

`ifdef AXI_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        rshown_q;
    logic [1:0]  wdly_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11, steps every cycle
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            lfsr_q   <= 16'hACE1;
            rshown_q <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            // once rvalid has been shown it must stay up until accepted
            if (r_hs)
                rshown_q <= 1'b0;
            else if (axi_rvalid)
                rshown_q <= 1'b1;
        end
    end

    assign w_allow = lfsr_q[0];
    assign r_allow = lfsr_q[5] | rshown_q;
`else
    assign w_allow = 1'b1;
    assign r_allow = 1'b1;
`endif

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q & w_allow;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = wid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q & r_allow;
    assign axi_rid     = rid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;

    assign w_hs    = axi_wvalid & axi_wready;
    assign r_hs    = axi_rvalid & axi_rready;
    assign w_final = (wcnt_q == wlen_q);
    // a wlast that disagrees with the beat count poisons the response
    assign werr_d  = werr_q | (axi_wlast != w_final);
    assign widx_d  = wfixed_q ? widx_q : widx_q + 1'b1;
    assign ridx_d  = rfixed_q ? ridx_q : ridx_q + 1'b1;
    assign ar_idx  = axi_araddr[MEM_AW+OFF-1:OFF];

    // Byte-lane RAM write; contents are deliberately not reset
    always_ff @(posedge axi_aclk) begin
        if (w_state_q == W_DATA && w_hs && !werr_q) begin
            for (int b = 0; b < BW; b++) begin
                if (axi_wstrb[b])
                    mem_q[widx_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

    // Write engine: burst ends on beat count, not on wlast
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wfixed_q  <= 1'b0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
`ifdef AXI_SLAVE_BACKPRESSURE_EN
            wdly_q    <= 2'd0;
`endif
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (axi_awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wid_q     <= axi_awid;
                        widx_q    <= axi_awaddr[MEM_AW+OFF-1:OFF];
                        wlen_q    <= axi_awlen;
                        wfixed_q  <= (axi_awburst == 2'b00);
                        werr_q    <= axi_awburst[1];
                        wcnt_q    <= '0;
                        w_state_q <= W_DATA;
`ifdef AXI_SLAVE_BACKPRESSURE_EN
                        wdly_q    <= lfsr_q[2:1];
                        wready_q  <= (lfsr_q[2:1] == 2'd0);
`else
                        wready_q  <= 1'b1;
`endif
                    end
                end
                W_DATA: begin
`ifdef AXI_SLAVE_BACKPRESSURE_EN
                    if (wdly_q != 2'd0) begin
                        wdly_q <= wdly_q - 1'b1;
                        if (wdly_q == 2'd1)
                            wready_q <= 1'b1;
                    end
`endif
                    if (w_hs) begin
                        werr_q <= werr_d;
                        if (w_final) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= werr_d ? 2'b10 : 2'b00;
                            w_state_q <= W_RESP;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                            widx_q <= widx_d;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read engine: rdata is loaded one beat ahead and held while stalled
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (axi_arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= axi_arid;
                        ridx_q    <= ar_idx;
                        rlen_q    <= axi_arlen;
                        rfixed_q  <= (axi_arburst == 2'b00);
                        rerr_q    <= axi_arburst[1];
                        rcnt_q    <= '0;
                        rdata_q   <= axi_arburst[1] ? '0 : mem_q[ar_idx];
                        rresp_q   <= axi_arburst[1] ? 2'b10 : 2'b00;
                        rlast_q   <= (axi_arlen == '0);
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= 2'b00;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + 1'b1;
                            ridx_q  <= ridx_d;
                            rdata_q <= rerr_q ? '0 : mem_q[ridx_d];
                            rlast_q <= (LSIZE'(rcnt_q + 1'b1) == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // address bits outside the word index are intentionally ignored
    logic unused_addr;
    assign unused_addr = ^{axi_awaddr[ASIZE-1:MEM_AW+OFF], axi_awaddr[OFF-1:0],
                           axi_araddr[ASIZE-1:MEM_AW+OFF], axi_araddr[OFF-1:0]};
endmodule
